shift_add_mult: RTL

Sequential 8x8 unsigned multiplier controller that drives the team's 8-bit two-stage CLA `adder` over eight add/shift iterations to form a 16-bit product. It sits between a simple start/done requester and the shared adder datapath. It sequences operand loading, conditional accumulation, shifting and result hand-off with a small FSM. One multiplication is in flight at a time; the product is held until the next accepted start.

---
 rtl/mult_pkg.sv | 14 +
 rtl/adder.sv | 34 +++
 rtl/shift_add_mult.sv | 98 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the shift-add multiplier
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ITER = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mult_state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 8-bit adder built from two cascaded 4-bit carry-lookahead groups, carry-in tied to 0
module adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       Cout,
  output logic [7:0] sum
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Flattened lookahead equations for one 4-bit group; returns carries into bits 1..4.
  function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp, input logic cin);
    logic [3:0] co;
    co[0] = gg[0] | (pp[0] & cin);
    co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
    co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & cin);
    co[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & cin);
    return co;
  endfunction

  always_comb begin
    g      = A & B;
    p      = A ^ B;
    c[0]   = 1'b0;
    c[4:1] = cla4(g[3:0], p[3:0], c[0]);
    c[8:5] = cla4(g[7:4], p[7:4], c[4]);
    sum    = p ^ c[7:0];
    Cout   = c[8];
  end

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential 8x8 unsigned shift-and-add multiplier driving the shared adder
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mult_state_t state_q, state_d;

  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   acc_post;
  logic               c_post;

  adder u_adder (
    .A    (acc_q),
    .B    (m_q),
    .Cout (add_cout),
    .sum  (add_sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The carry only lives between the add and the shift; after the shift it is always 0,
  // so it is kept as a combinational bit rather than a flop.
  always_comb begin
    c_post    = q_q[0] ? add_cout : 1'b0;
    acc_post  = q_q[0] ? add_sum : acc_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = a;
          q_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      CALC: begin
        acc_d = {c_post, acc_post[WIDTH-1:1]};
        q_d   = {acc_post[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) product_d = {acc_d, q_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
